// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle RV32I-subset controller.
// Everything the FSM, the decoder and the datapath need to agree on lives here.
package multicycle_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_TRAP     = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    CLS_R     = 2'd0,
    CLS_I     = 2'd1,
    CLS_LOAD  = 2'd2,
    CLS_STORE = 2'd3
  } iclass_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle. The master modport is the controller
// side; the slave modport is the datapath plus shared memory.
interface multicycle_controller_if;

  logic [6:0] Op;
  logic [2:0] Funct3;
  logic [6:0] Funct7;
  logic       MemReady;

  logic       MemReq;
  logic       MemWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       ImmSrc;
  logic [1:0] ULASrcA;
  logic [1:0] ULASrcB;
  logic [2:0] ULAControl;
  logic [1:0] ResultSrc;
  logic       InstrDone;
  logic       Illegal;

  modport master (
    input  Op, Funct3, Funct7, MemReady,
    output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ImmSrc,
           ULASrcA, ULASrcB, ULAControl, ResultSrc, InstrDone, Illegal
  );

  modport slave (
    output Op, Funct3, Funct7, MemReady,
    input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ImmSrc,
           ULASrcA, ULASrcB, ULAControl, ResultSrc, InstrDone, Illegal
  );

endinterface

// File: rtl/mc_alu_decoder.sv
// Combinational instruction classifier: opcode/funct fields to legality,
// instruction class and the ALU code used by R-type execution.
module mc_alu_decoder
  import multicycle_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       legal,
  output iclass_t    iclass,
  output logic [2:0] alu_ctl
);

  always_comb begin
    legal   = 1'b0;
    iclass  = CLS_R;
    alu_ctl = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        iclass = CLS_R;
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD:  begin legal = 1'b1; alu_ctl = ALU_ADD; end
            F3_AND:  begin legal = 1'b1; alu_ctl = ALU_AND; end
            F3_OR:   begin legal = 1'b1; alu_ctl = ALU_OR;  end
            F3_SLT:  begin legal = 1'b1; alu_ctl = ALU_SLT; end
            default: legal = 1'b0;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          legal   = 1'b1;
          alu_ctl = ALU_SUB;
        end
      end
      // Non-R classes always add; funct7 is immediate bits there.
      OP_IMM: begin
        iclass = CLS_I;
        legal  = (funct3 == F3_ADD);
      end
      OP_LOAD: begin
        iclass = CLS_LOAD;
        legal  = (funct3 == F3_ADD);
      end
      OP_STORE: begin
        iclass = CLS_STORE;
        legal  = (funct3 == F3_ADD);
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for ADD/SUB/AND/OR/SLT/ADDI/LB/SB on a shared
// instruction/data memory with a ready handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instruction at PC; PC+4 and IR load on MemReady
// DECODE   | classify instruction, latch class/ALU code, OldPC+imm
// MEMADR   | compute RD1 + imm address (S-type imm for stores)
// MEMREAD  | load request at ALUOut, hold until MemReady
// MEMWB    | write loaded byte to register file
// MEMWRITE | store request at ALUOut, hold until MemReady
// EXECR    | RD1 op RD2 with latched ALU code
// EXECI    | RD1 + I-type immediate
// ALUWB    | write ALUOut to register file
// TRAP     | illegal encoding; sticky until reset
module multicycle_controller
  import multicycle_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);

  state_t     state;
  iclass_t    cls_q;
  logic [2:0] alu_q;

  logic       dec_legal;
  iclass_t    dec_class;
  logic [2:0] dec_alu;

  mc_alu_decoder u_dec (
    .op      (bus.Op),
    .funct3  (bus.Funct3),
    .funct7  (bus.Funct7),
    .legal   (dec_legal),
    .iclass  (dec_class),
    .alu_ctl (dec_alu)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FETCH;
      cls_q <= CLS_R;
      alu_q <= ALU_ADD;
    end else begin
      case (state)
        ST_FETCH:    if (bus.MemReady) state <= ST_DECODE;
        ST_DECODE: begin
          cls_q <= dec_class;
          alu_q <= dec_alu;
          if (!dec_legal) begin
            state <= ST_TRAP;
          end else begin
            case (dec_class)
              CLS_R:   state <= ST_EXECR;
              CLS_I:   state <= ST_EXECI;
              default: state <= ST_MEMADR;
            endcase
          end
        end
        ST_MEMADR:   state <= (cls_q == CLS_STORE) ? ST_MEMWRITE : ST_MEMREAD;
        ST_MEMREAD:  if (bus.MemReady) state <= ST_MEMWB;
        ST_MEMWB:    state <= ST_FETCH;
        ST_MEMWRITE: if (bus.MemReady) state <= ST_FETCH;
        ST_EXECR:    state <= ST_ALUWB;
        ST_EXECI:    state <= ST_ALUWB;
        ST_ALUWB:    state <= ST_FETCH;
        ST_TRAP:     state <= ST_TRAP;
        default:     state <= ST_FETCH;
      endcase
    end
  end

  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       imm_src;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic [2:0] alu_ctl;
  logic [1:0] result_src;
  logic       instr_done;
  logic       illegal;

  // Only the handshake strobes look at MemReady; everything else is Moore.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    imm_src    = 1'b0;
    src_a      = SRCA_PC;
    src_b      = SRCB_RD2;
    alu_ctl    = ALU_ADD;
    result_src = RES_ALUOUT;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req    = 1'b1;
        src_a      = SRCA_PC;
        src_b      = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = bus.MemReady;
        pc_write   = bus.MemReady;
      end
      ST_DECODE: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
      end
      ST_MEMADR: begin
        src_a   = SRCA_RD1;
        src_b   = SRCB_IMM;
        imm_src = (cls_q == CLS_STORE);
      end
      ST_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      ST_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_MEMWRITE: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        adr_src    = 1'b1;
        instr_done = bus.MemReady;
      end
      ST_EXECR: begin
        src_a   = SRCA_RD1;
        src_b   = SRCB_RD2;
        alu_ctl = alu_q;
      end
      ST_EXECI: begin
        src_a = SRCA_RD1;
        src_b = SRCB_IMM;
      end
      ST_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_TRAP: illegal = 1'b1;
      default: illegal = 1'b0;
    endcase

    // Reset parks the FSM in FETCH, but nothing may be requested until release.
    if (rst) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      imm_src    = 1'b0;
      src_a      = SRCA_PC;
      src_b      = SRCB_RD2;
      alu_ctl    = ALU_ADD;
      result_src = RES_ALUOUT;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign bus.MemReq     = mem_req;
  assign bus.MemWrite   = mem_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.IRWrite    = ir_write;
  assign bus.PCWrite    = pc_write;
  assign bus.RegWrite   = reg_write;
  assign bus.ImmSrc     = imm_src;
  assign bus.ULASrcA    = src_a;
  assign bus.ULASrcB    = src_b;
  assign bus.ULAControl = alu_ctl;
  assign bus.ResultSrc  = result_src;
  assign bus.InstrDone  = instr_done;
  assign bus.Illegal    = illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle vectors built from instruction-level
// rules (directed list, hand-built reset corner cases, then random instructions).
module tb_multicycle_controller;

  typedef struct packed {
    logic       MemReq;
    logic       MemWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       ImmSrc;
    logic [1:0] ULASrcA;
    logic [1:0] ULASrcB;
    logic [2:0] ULAControl;
    logic [1:0] ResultSrc;
    logic       InstrDone;
    logic       Illegal;
  } ctl_t;

  typedef struct {
    logic        rst;
    logic        ready;
    logic [31:0] instr;
    ctl_t        exp;
    int          tag;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vec_t vecs[$];
  int   cur_tag = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic logic rbit();
    return ($urandom & 32'd1) != 32'd0;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7);
    logic [31:0] r;
    r = $urandom;
    return {f7, r[24:15], f3, r[11:7], op};
  endfunction

  // Instruction-level reference: 0 illegal, 1 R, 2 ADDI, 3 LB, 4 SB.
  function automatic int ref_class(input logic [31:0] w, output logic [2:0] code);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    code = 3'b000;
    if (op == 7'b0110011) begin
      if (f3 == 3'b000 && f7 == 7'b0000000) begin code = 3'b000; return 1; end
      if (f3 == 3'b000 && f7 == 7'b0100000) begin code = 3'b001; return 1; end
      if (f3 == 3'b111 && f7 == 7'b0000000) begin code = 3'b010; return 1; end
      if (f3 == 3'b110 && f7 == 7'b0000000) begin code = 3'b011; return 1; end
      if (f3 == 3'b010 && f7 == 7'b0000000) begin code = 3'b101; return 1; end
      return 0;
    end
    if (f3 != 3'b000) return 0;
    if (op == 7'b0010011) return 2;
    if (op == 7'b0000011) return 3;
    if (op == 7'b0100011) return 4;
    return 0;
  endfunction

  task automatic push(input logic r, input logic rdy, input logic [31:0] w, input ctl_t e);
    vec_t v;
    v.rst = r;
    v.ready = rdy;
    v.instr = w;
    v.exp = e;
    v.tag = cur_tag;
    vecs.push_back(v);
  endtask

  function automatic ctl_t fetch_c(input logic done);
    ctl_t c;
    c = '0;
    c.MemReq = 1'b1;
    c.ULASrcB = 2'b10;
    c.ResultSrc = 2'b10;
    c.IRWrite = done;
    c.PCWrite = done;
    return c;
  endfunction

  function automatic ctl_t wb_c(input logic [1:0] rs);
    ctl_t c;
    c = '0;
    c.ResultSrc = rs;
    c.RegWrite = 1'b1;
    c.InstrDone = 1'b1;
    return c;
  endfunction

  function automatic ctl_t decode_c();
    ctl_t c;
    c = '0;
    c.ULASrcA = 2'b01;
    c.ULASrcB = 2'b01;
    return c;
  endfunction

  function automatic ctl_t memadr_c(input logic store);
    ctl_t c;
    c = '0;
    c.ULASrcA = 2'b10;
    c.ULASrcB = 2'b01;
    c.ImmSrc = store;
    return c;
  endfunction

  function automatic ctl_t memwrite_c(input logic done);
    ctl_t c;
    c = '0;
    c.MemReq = 1'b1;
    c.MemWrite = 1'b1;
    c.AdrSrc = 1'b1;
    c.InstrDone = done;
    return c;
  endfunction

  task automatic push_reset(input int n);
    for (int i = 0; i < n; i++) push(1'b1, rbit(), $urandom, '0);
  endtask

  // Expands one instruction into its expected cycles. fw/mw are wait cycles in
  // fetch / memory phase; ntrap cycles of TRAP are appended for illegal words.
  task automatic gen_instr(input logic [31:0] w, input int fw, input int mw,
                           input int ntrap, output int k);
    ctl_t c;
    logic [2:0] code;
    cur_tag++;
    for (int i = 0; i < fw; i++) push(1'b0, 1'b0, $urandom, fetch_c(1'b0));
    push(1'b0, 1'b1, $urandom, fetch_c(1'b1));
    push(1'b0, rbit(), w, decode_c());
    k = ref_class(w, code);
    c = '0;
    case (k)
      1: begin
        c.ULASrcA = 2'b10;
        c.ULAControl = code;
        push(1'b0, rbit(), $urandom, c);
        push(1'b0, rbit(), $urandom, wb_c(2'b00));
      end
      2: begin
        c.ULASrcA = 2'b10;
        c.ULASrcB = 2'b01;
        push(1'b0, rbit(), $urandom, c);
        push(1'b0, rbit(), $urandom, wb_c(2'b00));
      end
      3: begin
        push(1'b0, rbit(), $urandom, memadr_c(1'b0));
        c.MemReq = 1'b1;
        c.AdrSrc = 1'b1;
        for (int i = 0; i < mw; i++) push(1'b0, 1'b0, $urandom, c);
        push(1'b0, 1'b1, $urandom, c);
        push(1'b0, rbit(), $urandom, wb_c(2'b01));
      end
      4: begin
        push(1'b0, rbit(), $urandom, memadr_c(1'b1));
        for (int i = 0; i < mw; i++) push(1'b0, 1'b0, $urandom, memwrite_c(1'b0));
        push(1'b0, 1'b1, $urandom, memwrite_c(1'b1));
      end
      default: begin
        c.Illegal = 1'b1;
        for (int i = 0; i < ntrap; i++) push(1'b0, rbit(), $urandom, c);
      end
    endcase
  endtask

  ctl_t act;
  int   kk;

  initial begin
    bus.Op = '0;
    bus.Funct3 = '0;
    bus.Funct7 = '0;
    bus.MemReady = 1'b0;

    // Directed list
    push_reset(2);
    gen_instr(32'h002081B3, 0, 0, 0, kk);
    gen_instr(mk(7'b0110011, 3'b000, 7'b0100000), 1, 0, 0, kk);
    gen_instr(mk(7'b0110011, 3'b111, 7'b0000000), 0, 0, 0, kk);
    gen_instr(mk(7'b0110011, 3'b110, 7'b0000000), 2, 0, 0, kk);
    gen_instr(mk(7'b0110011, 3'b010, 7'b0000000), 0, 0, 0, kk);
    gen_instr(mk(7'b0010011, 3'b000, 7'($urandom)), 0, 0, 0, kk);
    gen_instr(mk(7'b0000011, 3'b000, 7'($urandom)), 0, 3, 0, kk);
    gen_instr(mk(7'b0100011, 3'b000, 7'($urandom)), 1, 2, 0, kk);
    gen_instr(mk(7'b0000011, 3'b000, 7'($urandom)), 0, 0, 0, kk);
    gen_instr(mk(7'b0100011, 3'b000, 7'($urandom)), 0, 0, 0, kk);

    // Reset in the middle of a stalled store, then a stalled restart fetch
    cur_tag++;
    push(1'b0, 1'b1, $urandom, fetch_c(1'b1));
    push(1'b0, 1'b0, mk(7'b0100011, 3'b000, 7'b0000000), decode_c());
    push(1'b0, 1'b0, $urandom, memadr_c(1'b1));
    push(1'b0, 1'b0, $urandom, memwrite_c(1'b0));
    push(1'b0, 1'b0, $urandom, memwrite_c(1'b0));
    push_reset(2);
    gen_instr(32'h002081B3, 2, 0, 0, kk);

    // Illegal encodings, sticky until reset
    gen_instr(mk(7'b1111111, 3'b000, 7'b0000000), 0, 0, 20, kk);
    push_reset(2);
    gen_instr(mk(7'b0110011, 3'b000, 7'b0000001), 0, 0, 20, kk);
    push_reset(1);
    gen_instr(mk(7'b0000011, 3'b001, 7'b0000000), 1, 0, 3, kk);
    push_reset(1);

    // Random instruction stream
    for (int n = 0; n < 80; n++) begin
      logic [31:0] w;
      int sel;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: w = mk(7'b0110011, 3'b000, 7'b0000000);
        1: w = mk(7'b0110011, 3'b000, 7'b0100000);
        2: w = mk(7'b0110011, 3'b111, 7'b0000000);
        3: w = mk(7'b0110011, 3'b110, 7'b0000000);
        4: w = mk(7'b0110011, 3'b010, 7'b0000000);
        5: w = mk(7'b0010011, 3'b000, 7'($urandom));
        6: w = mk(7'b0000011, 3'b000, 7'($urandom));
        7: w = mk(7'b0100011, 3'b000, 7'($urandom));
        default: w = $urandom;
      endcase
      gen_instr(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 4, kk);
      if (kk == 0) push_reset(2);
    end

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      bus.MemReady = vecs[i].ready;
      bus.Op = vecs[i].instr[6:0];
      bus.Funct3 = vecs[i].instr[14:12];
      bus.Funct7 = vecs[i].instr[31:25];
      #2;
      act = {bus.MemReq, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite,
             bus.RegWrite, bus.ImmSrc, bus.ULASrcA, bus.ULASrcB, bus.ULAControl,
             bus.ResultSrc, bus.InstrDone, bus.Illegal};
      n_checks++;
      if (act !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL ctl vec=%0d instr=%0d rst=%0b ready=%0b got=%05h exp=%05h",
                 i, vecs[i].tag, vecs[i].rst, vecs[i].ready, act, vecs[i].exp);
      end
      if (vecs[i].rst) begin
        n_checks++;
        if (act !== '0) begin
          n_fail++;
          $display("FAIL reset-state vec=%0d outputs=%05h not all zero", i, act);
        end
      end
      if (vecs[i].exp.Illegal) begin
        n_checks++;
        if (bus.Illegal !== 1'b1 || bus.MemReq !== 1'b0 || bus.MemWrite !== 1'b0) begin
          n_fail++;
          $display("FAIL trap-hold vec=%0d instr=%0d Illegal=%0b MemReq=%0b MemWrite=%0b",
                   i, vecs[i].tag, bus.Illegal, bus.MemReq, bus.MemWrite);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
